csr_access_sequencer: RTL and testbench



---
 rtl/csr_access_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 tb/tb_csr_access_sequencer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_access_sequencer.sv
// Sequences every CSR access (pipeline instructions, trap entry, mret) into the
// 3-cycle csr handshake. Build option CSR_SEQ_MPIE_EN adds MPIE save/restore.

`ifndef MSR_MSTATUS
`define MSR_MSTATUS 12'h300
`endif
`ifndef MSR_MTVEC
`define MSR_MTVEC 12'h305
`endif
`ifndef MSR_MEPC
`define MSR_MEPC 12'h341
`endif
`ifndef MSR_MCAUSE
`define MSR_MCAUSE 12'h342
`endif
`ifndef MSR_MTVAL
`define MSR_MTVAL 12'h343
`endif

module csr_access_sequencer #(
    parameter int CSR_DATA_WIDTH = 32,
    parameter int CSR_ADDR_WIDTH = 12
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      instr_req_i,
    input  logic [1:0]                instr_op_i,
    input  logic [CSR_ADDR_WIDTH-1:0] instr_addr_i,
    input  logic [CSR_DATA_WIDTH-1:0] instr_wdata_i,
    output logic                      instr_ack_o,
    output logic                      instr_err_o,
    output logic [CSR_DATA_WIDTH-1:0] instr_rdata_o,
    input  logic                      trap_req_i,
    input  logic [CSR_DATA_WIDTH-1:0] trap_cause_i,
    input  logic [CSR_DATA_WIDTH-1:0] trap_epc_i,
    input  logic [CSR_DATA_WIDTH-1:0] trap_tval_i,
    output logic                      trap_done_o,
    output logic [CSR_DATA_WIDTH-1:0] trap_vector_o,
    input  logic                      mret_req_i,
    output logic                      mret_done_o,
    output logic [CSR_DATA_WIDTH-1:0] mret_pc_o,
    output logic                      seq_busy_o,
    output logic                      csr_en_o,
    output logic [1:0]                csr_op_o,
    output logic [CSR_ADDR_WIDTH-1:0] csr_addr_o,
    output logic [CSR_DATA_WIDTH-1:0] csr_wdata_o,
    input  logic [CSR_DATA_WIDTH-1:0] csr_rdata_i,
    input  logic                      csr_busy_i
);

    localparam logic [1:0] OP_SET     = 2'd0;
    localparam logic [1:0] OP_WRITE   = 2'd1;
    localparam logic [1:0] OP_CLEAR   = 2'd2;
    localparam logic [1:0] OP_ILLEGAL = 2'd3;

    localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MSTATUS = CSR_ADDR_WIDTH'(`MSR_MSTATUS);
    localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MTVEC   = CSR_ADDR_WIDTH'(`MSR_MTVEC);
    localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MEPC    = CSR_ADDR_WIDTH'(`MSR_MEPC);
    localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MCAUSE  = CSR_ADDR_WIDTH'(`MSR_MCAUSE);
    localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MTVAL   = CSR_ADDR_WIDTH'(`MSR_MTVAL);

    localparam logic [CSR_DATA_WIDTH-1:0] MIE_MASK  = CSR_DATA_WIDTH'(32'h8);

`ifdef CSR_SEQ_MPIE_EN
    localparam logic [CSR_DATA_WIDTH-1:0] MPIE_MASK = CSR_DATA_WIDTH'(32'h80);
    localparam logic [2:0] TRAP_LAST    = 3'd5;
    localparam logic [2:0] MRET_LAST    = 3'd2;
    localparam logic [2:0] MRET_PC_STEP = 3'd2;
`else
    localparam logic [2:0] TRAP_LAST    = 3'd4;
    localparam logic [2:0] MRET_LAST    = 3'd1;
    localparam logic [2:0] MRET_PC_STEP = 3'd0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_HI,
        S_WAIT_LO,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        SEQ_INSTR,
        SEQ_TRAP,
        SEQ_MRET
    } seq_t;

    state_t state_reg, state_next;
    seq_t   seq_reg, seq_next;
    logic [2:0] step_reg, step_next;
    logic [2:0] last_step;

    logic [CSR_DATA_WIDTH-1:0] cause_reg, cause_next;
    logic [CSR_DATA_WIDTH-1:0] epc_reg, epc_next;
    logic [CSR_DATA_WIDTH-1:0] tval_reg, tval_next;

    logic                      ack_reg, ack_next;
    logic                      err_reg, err_next;
    logic [CSR_DATA_WIDTH-1:0] rdata_reg, rdata_next;
    logic                      trap_done_reg, trap_done_next;
    logic [CSR_DATA_WIDTH-1:0] vector_reg, vector_next;
    logic                      mret_done_reg, mret_done_next;
    logic [CSR_DATA_WIDTH-1:0] pc_reg, pc_next;
    logic                      busy_reg;
    logic                      csr_en_reg;
    logic [1:0]                csr_op_reg;
    logic [CSR_ADDR_WIDTH-1:0] csr_addr_reg;
    logic [CSR_DATA_WIDTH-1:0] csr_wdata_reg;

    logic [1:0]                dec_op;
    logic [CSR_ADDR_WIDTH-1:0] dec_addr;
    logic [CSR_DATA_WIDTH-1:0] dec_wdata;

`ifdef CSR_SEQ_MPIE_EN
    logic [CSR_DATA_WIDTH-1:0] mstatus_old_reg, mstatus_old_next;
    logic [CSR_DATA_WIDTH-1:0] trap_mstatus;
    logic [CSR_DATA_WIDTH-1:0] mret_mstatus;

    // Trap: MPIE <= MIE, MIE <= 0. Mret: MIE <= MPIE, MPIE <= 1.
    assign trap_mstatus = (mstatus_old_next & ~(MIE_MASK | MPIE_MASK))
                        | (mstatus_old_next[3] ? MPIE_MASK : '0);
    assign mret_mstatus = (mstatus_old_next & ~MIE_MASK)
                        | (mstatus_old_next[7] ? MIE_MASK : '0) | MPIE_MASK;
`endif

    always_comb begin
        last_step = 3'd0;
        if (seq_reg == SEQ_TRAP) begin
            last_step = TRAP_LAST;
        end else if (seq_reg == SEQ_MRET) begin
            last_step = MRET_LAST;
        end
    end

    // Sequencing: arbitration in IDLE, handshake tracking, result capture.
    always_comb begin
        state_next     = state_reg;
        seq_next       = seq_reg;
        step_next      = step_reg;
        cause_next     = cause_reg;
        epc_next       = epc_reg;
        tval_next      = tval_reg;
        ack_next       = 1'b0;
        err_next       = 1'b0;
        rdata_next     = rdata_reg;
        trap_done_next = 1'b0;
        vector_next    = vector_reg;
        mret_done_next = 1'b0;
        pc_next        = pc_reg;
`ifdef CSR_SEQ_MPIE_EN
        mstatus_old_next = mstatus_old_reg;
`endif
        case (state_reg)
            S_IDLE: begin
                if (!csr_busy_i) begin
                    if (trap_req_i) begin
                        seq_next   = SEQ_TRAP;
                        step_next  = 3'd0;
                        cause_next = trap_cause_i;
                        epc_next   = trap_epc_i;
                        tval_next  = trap_tval_i;
                        state_next = S_ISSUE;
                    end else if (mret_req_i) begin
                        seq_next   = SEQ_MRET;
                        step_next  = 3'd0;
                        state_next = S_ISSUE;
                    end else if (instr_req_i) begin
                        seq_next  = SEQ_INSTR;
                        step_next = 3'd0;
                        if (instr_op_i == OP_ILLEGAL) begin
                            state_next = S_DONE;
                            ack_next   = 1'b1;
                            err_next   = 1'b1;
                            rdata_next = '0;
                        end else begin
                            state_next = S_ISSUE;
                        end
                    end
                end
            end
            S_ISSUE: state_next = S_WAIT_HI;
            S_WAIT_HI: begin
                if (csr_busy_i) begin
                    state_next = S_WAIT_LO;
                end
            end
            S_WAIT_LO: begin
                if (!csr_busy_i) begin
                    if (seq_reg == SEQ_INSTR) begin
                        rdata_next = csr_rdata_i;
                    end
                    if (seq_reg == SEQ_TRAP && step_reg == TRAP_LAST) begin
                        vector_next = csr_rdata_i;
                    end
                    if (seq_reg == SEQ_MRET && step_reg == MRET_PC_STEP) begin
                        pc_next = csr_rdata_i;
                    end
`ifdef CSR_SEQ_MPIE_EN
                    if ((seq_reg == SEQ_TRAP && step_reg == 3'd3) ||
                        (seq_reg == SEQ_MRET && step_reg == 3'd0)) begin
                        mstatus_old_next = csr_rdata_i;
                    end
`endif
                    if (step_reg == last_step) begin
                        state_next     = S_DONE;
                        ack_next       = (seq_reg == SEQ_INSTR);
                        trap_done_next = (seq_reg == SEQ_TRAP);
                        mret_done_next = (seq_reg == SEQ_MRET);
                    end else begin
                        step_next  = step_reg + 3'd1;
                        state_next = S_ISSUE;
                    end
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Access decode for the step about to be issued; uses next-state values so
    // operands latched or captured on the same edge are already visible.
    always_comb begin
        dec_addr  = instr_addr_i;
        dec_op    = instr_op_i;
        dec_wdata = instr_wdata_i;
        if (seq_next == SEQ_TRAP) begin
            dec_op    = OP_WRITE;
            dec_wdata = '0;
            case (step_next)
                3'd0: begin dec_addr = ADDR_MEPC;   dec_wdata = epc_next;   end
                3'd1: begin dec_addr = ADDR_MCAUSE; dec_wdata = cause_next; end
                3'd2: begin dec_addr = ADDR_MTVAL;  dec_wdata = tval_next;  end
`ifdef CSR_SEQ_MPIE_EN
                3'd3: begin dec_addr = ADDR_MSTATUS; dec_op = OP_SET; end
                3'd4: begin dec_addr = ADDR_MSTATUS; dec_wdata = trap_mstatus; end
`else
                3'd3: begin dec_addr = ADDR_MSTATUS; dec_op = OP_CLEAR; dec_wdata = MIE_MASK; end
`endif
                default: begin dec_addr = ADDR_MTVEC; dec_op = OP_SET; end
            endcase
        end else if (seq_next == SEQ_MRET) begin
            dec_op    = OP_SET;
            dec_wdata = '0;
            case (step_next)
`ifdef CSR_SEQ_MPIE_EN
                3'd0: dec_addr = ADDR_MSTATUS;
                3'd1: begin dec_addr = ADDR_MSTATUS; dec_op = OP_WRITE; dec_wdata = mret_mstatus; end
                default: dec_addr = ADDR_MEPC;
`else
                3'd0: dec_addr = ADDR_MEPC;
                default: begin dec_addr = ADDR_MSTATUS; dec_wdata = MIE_MASK; end
`endif
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg     <= S_IDLE;
            seq_reg       <= SEQ_INSTR;
            step_reg      <= 3'd0;
            cause_reg     <= '0;
            epc_reg       <= '0;
            tval_reg      <= '0;
            ack_reg       <= 1'b0;
            err_reg       <= 1'b0;
            rdata_reg     <= '0;
            trap_done_reg <= 1'b0;
            vector_reg    <= '0;
            mret_done_reg <= 1'b0;
            pc_reg        <= '0;
            busy_reg      <= 1'b0;
            csr_en_reg    <= 1'b0;
            csr_op_reg    <= '0;
            csr_addr_reg  <= '0;
            csr_wdata_reg <= '0;
`ifdef CSR_SEQ_MPIE_EN
            mstatus_old_reg <= '0;
`endif
        end else begin
            state_reg     <= state_next;
            seq_reg       <= seq_next;
            step_reg      <= step_next;
            cause_reg     <= cause_next;
            epc_reg       <= epc_next;
            tval_reg      <= tval_next;
            ack_reg       <= ack_next;
            err_reg       <= err_next;
            rdata_reg     <= rdata_next;
            trap_done_reg <= trap_done_next;
            vector_reg    <= vector_next;
            mret_done_reg <= mret_done_next;
            pc_reg        <= pc_next;
            busy_reg      <= (state_next != S_IDLE);
            csr_en_reg    <= (state_next == S_ISSUE);
`ifdef CSR_SEQ_MPIE_EN
            mstatus_old_reg <= mstatus_old_next;
`endif
            // Access fields change only on entry to ISSUE, so they stay stable
            // through the csr unit's write cycle.
            if (state_next == S_ISSUE) begin
                csr_op_reg    <= dec_op;
                csr_addr_reg  <= dec_addr;
                csr_wdata_reg <= dec_wdata;
            end
        end
    end

    assign instr_ack_o   = ack_reg;
    assign instr_err_o   = err_reg;
    assign instr_rdata_o = rdata_reg;
    assign trap_done_o   = trap_done_reg;
    assign trap_vector_o = vector_reg;
    assign mret_done_o   = mret_done_reg;
    assign mret_pc_o     = pc_reg;
    assign seq_busy_o    = busy_reg;
    assign csr_en_o      = csr_en_reg;
    assign csr_op_o      = csr_op_reg;
    assign csr_addr_o    = csr_addr_reg;
    assign csr_wdata_o   = csr_wdata_reg;

endmodule

// File: tb/tb_csr_access_sequencer.sv
// Directed bench for csr_access_sequencer with a small 3-cycle csr unit stub.
// Expectations follow CSR_SEQ_MPIE_EN when that macro is defined.

module tb_csr_access_sequencer;

`ifdef CSR_SEQ_MPIE_EN
    localparam int          TRAP_LAT   = 25;
    localparam int          TRAP_STEPS = 6;
    localparam int          MRET_LAT   = 13;
    localparam logic [31:0] MST_TRAP   = 32'h80;
    localparam logic [31:0] MST_MRET   = 32'h88;
`else
    localparam int          TRAP_LAT   = 21;
    localparam int          TRAP_STEPS = 5;
    localparam int          MRET_LAT   = 9;
    localparam logic [31:0] MST_TRAP   = 32'h0;
    localparam logic [31:0] MST_MRET   = 32'h8;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_req = 1'b0;
    logic [1:0]  instr_op = 2'd0;
    logic [11:0] instr_addr = 12'h0;
    logic [31:0] instr_wdata = 32'h0;
    logic        instr_ack, instr_err;
    logic [31:0] instr_rdata;
    logic        trap_req = 1'b0;
    logic [31:0] trap_cause = 32'h0, trap_epc = 32'h0, trap_tval = 32'h0;
    logic        trap_done;
    logic [31:0] trap_vector;
    logic        mret_req = 1'b0;
    logic        mret_done;
    logic [31:0] mret_pc;
    logic        seq_busy, csr_en;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] stub_rdata;
    logic        stub_busy;

    int checks_count = 0;
    int errors_count = 0;

    always #5 clk = ~clk;

    csr_access_sequencer #(.CSR_DATA_WIDTH(32), .CSR_ADDR_WIDTH(12)) dut (
        .clk_i(clk), .rst_i(rst),
        .instr_req_i(instr_req), .instr_op_i(instr_op), .instr_addr_i(instr_addr),
        .instr_wdata_i(instr_wdata), .instr_ack_o(instr_ack), .instr_err_o(instr_err),
        .instr_rdata_o(instr_rdata),
        .trap_req_i(trap_req), .trap_cause_i(trap_cause), .trap_epc_i(trap_epc),
        .trap_tval_i(trap_tval), .trap_done_o(trap_done), .trap_vector_o(trap_vector),
        .mret_req_i(mret_req), .mret_done_o(mret_done), .mret_pc_o(mret_pc),
        .seq_busy_o(seq_busy), .csr_en_o(csr_en), .csr_op_o(csr_op),
        .csr_addr_o(csr_addr), .csr_wdata_o(csr_wdata),
        .csr_rdata_i(stub_rdata), .csr_busy_i(stub_busy)
    );

    // csr unit stub: busy for two cycles after csr_en, result and write on the third edge
    logic [31:0] csr_mem [0:4095];
    logic [1:0]  stub_cnt;
    logic [11:0] lat_addr;
    logic [1:0]  lat_op;
    logic [31:0] lat_wdata;
    logic        pl_en = 1'b0;
    logic [11:0] pl_addr = 12'h0;
    logic [31:0] pl_data = 32'h0;

    always @(posedge clk) begin
        if (rst) begin
            stub_busy <= 1'b0;
            stub_cnt  <= 2'd0;
        end else begin
            if (pl_en) csr_mem[pl_addr] <= pl_data;
            case (stub_cnt)
                2'd0: if (csr_en) begin
                    stub_cnt  <= 2'd1;
                    stub_busy <= 1'b1;
                    lat_addr  <= csr_addr;
                    lat_op    <= csr_op;
                    lat_wdata <= csr_wdata;
                end
                2'd1: stub_cnt <= 2'd2;
                default: begin
                    stub_cnt   <= 2'd0;
                    stub_busy  <= 1'b0;
                    stub_rdata <= csr_mem[csr_addr];
                    case (csr_op)
                        2'd0: csr_mem[csr_addr] <= csr_mem[csr_addr] | csr_wdata;
                        2'd1: csr_mem[csr_addr] <= csr_wdata;
                        2'd2: csr_mem[csr_addr] <= csr_mem[csr_addr] & ~csr_wdata;
                        default: ;
                    endcase
                end
            endcase
        end
    end

    int   en_count = 0;
    int   en_double = 0;
    int   hold_err = 0;
    logic en_prev = 1'b0;

    always @(posedge clk) begin
        if (!rst) begin
            if (csr_en) en_count <= en_count + 1;
            if (csr_en && en_prev) en_double <= en_double + 1;
            if (stub_cnt != 2'd0 &&
                (csr_addr != lat_addr || csr_op != lat_op || csr_wdata != lat_wdata))
                hold_err <= hold_err + 1;
        end
        en_prev <= csr_en;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_count++;
        if (got !== exp) begin
            errors_count++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s value=0x%08h", tag, got);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic preload(input logic [11:0] a, input logic [31:0] d);
        pl_addr = a;
        pl_data = d;
        pl_en   = 1'b1;
        tick(1);
        pl_en   = 1'b0;
    endtask

    // Called one step after a clock edge with the DUT idle; returns cycles to ack.
    task automatic instr_txn(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd,
                             output int lat, output logic [31:0] rd, output logic err);
        instr_op    = op;
        instr_addr  = a;
        instr_wdata = wd;
        instr_req   = 1'b1;
        lat = 0;
        do begin
            tick(1);
            lat++;
        end while (!instr_ack && lat < 100);
        rd  = instr_rdata;
        err = instr_err;
        instr_req = 1'b0;
        tick(1);
    endtask

    initial begin
        int          lat, n, en0;
        logic [31:0] rd;
        logic        err;
        logic        saw_ack;

        for (int i = 0; i < 8; i++) csr_mem[12'h340 + 12'(i)] = 32'h0;
        csr_mem[12'h300] = 32'h0;
        csr_mem[12'h305] = 32'h0;

        tick(3);
        check("reset_outputs", 32'({csr_en, instr_ack, instr_err, trap_done, mret_done, seq_busy}), 32'h0);
        check("reset_addr", 32'(csr_addr), 32'h0);
        rst = 1'b0;
        tick(1);

        // instr write then read-back through set with zero mask
        en0 = en_count;
        instr_txn(2'd1, 12'h340, 32'hDEADBEEF, lat, rd, err);
        check("wr_lat", 32'(lat), 32'd5);
        check("wr_old", rd, 32'h0);
        check("wr_err", 32'(err), 32'h0);
        check("wr_en_pulses", 32'(en_count - en0), 32'd1);
        instr_txn(2'd0, 12'h340, 32'h0, lat, rd, err);
        check("set_lat", 32'(lat), 32'd5);
        check("set_old", rd, 32'hDEADBEEF);

        // trap and instr together: trap wins, operands latched at acceptance
        preload(12'h305, 32'h80);
        preload(12'h300, 32'h8);
        en0 = en_count;
        trap_cause = 32'hB; trap_epc = 32'h100; trap_tval = 32'h44; trap_req = 1'b1;
        instr_op = 2'd1; instr_addr = 12'h340; instr_wdata = 32'h1234; instr_req = 1'b1;
        n = 0; saw_ack = 1'b0;
        do begin
            tick(1);
            n++;
            if (n == 1) begin
                trap_cause = 32'hFFFF_FFFF; trap_epc = 32'hFFFF_FFFF; trap_tval = 32'hFFFF_FFFF;
            end
            if (instr_ack) saw_ack = 1'b1;
        end while (!trap_done && n < 100);
        check("trap_lat", 32'(n), 32'(TRAP_LAT));
        check("trap_vector", trap_vector, 32'h80);
        check("trap_en_pulses", 32'(en_count - en0), 32'(TRAP_STEPS));
        check("trap_no_instr_ack", 32'(saw_ack), 32'h0);
        trap_req = 1'b0;
        n = 0;
        do begin
            tick(1);
            n++;
        end while (!instr_ack && n < 100);
        check("instr_after_trap_lat", 32'(n), 32'd6);
        check("instr_after_trap_old", instr_rdata, 32'hDEADBEEF);
        instr_req = 1'b0;
        tick(1);
        instr_txn(2'd0, 12'h341, 32'h0, lat, rd, err);
        check("mepc_rb", rd, 32'h100);
        instr_txn(2'd0, 12'h342, 32'h0, lat, rd, err);
        check("mcause_rb", rd, 32'hB);
        instr_txn(2'd0, 12'h343, 32'h0, lat, rd, err);
        check("mtval_rb", rd, 32'h44);
        instr_txn(2'd0, 12'h300, 32'h0, lat, rd, err);
        check("mstatus_after_trap", rd, MST_TRAP);

        // mret
        preload(12'h341, 32'h2000);
        mret_req = 1'b1;
        n = 0;
        do begin
            tick(1);
            n++;
        end while (!mret_done && n < 100);
        check("mret_lat", 32'(n), 32'(MRET_LAT));
        check("mret_pc", mret_pc, 32'h2000);
        mret_req = 1'b0;
        tick(1);
        instr_txn(2'd0, 12'h300, 32'h0, lat, rd, err);
        check("mstatus_after_mret", rd, MST_MRET);

        // illegal op: immediate ack, no csr access
        en0 = en_count;
        instr_txn(2'd3, 12'h340, 32'h5555_5555, lat, rd, err);
        check("illegal_lat", 32'(lat), 32'd1);
        check("illegal_err", 32'(err), 32'h1);
        check("illegal_rdata", rd, 32'h0);
        tick(2);
        check("illegal_no_en", 32'(en_count - en0), 32'd0);

        // reset during the mtval write of a trap
        trap_cause = 32'h22; trap_epc = 32'h300; trap_tval = 32'h77; trap_req = 1'b1;
        tick(10);
        rst = 1'b1;
        tick(1);
        check("rst_mid_flags", 32'({csr_en, instr_ack, instr_err, trap_done, mret_done, seq_busy}), 32'h0);
        check("rst_mid_addr_data", 32'(csr_addr) | csr_wdata | 32'(csr_op), 32'h0);
        check("rst_mid_results", instr_rdata | trap_vector | mret_pc, 32'h0);
        rst = 1'b0;
        trap_req = 1'b0;
        en0 = en_count;
        tick(10);
        check("rst_no_en", 32'(en_count - en0), 32'd0);
        trap_cause = 32'h5; trap_epc = 32'h400; trap_tval = 32'h99; trap_req = 1'b1;
        n = 0;
        do begin
            tick(1);
            n++;
        end while (!trap_done && n < 100);
        check("trap2_lat", 32'(n), 32'(TRAP_LAT));
        check("trap2_vector", trap_vector, 32'h80);
        trap_req = 1'b0;
        tick(1);
        instr_txn(2'd0, 12'h343, 32'h0, lat, rd, err);
        check("trap2_mtval_rb", rd, 32'h99);

        check("csr_field_hold", 32'(hold_err), 32'h0);
        check("csr_en_single", 32'(en_double), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks_count, errors_count);
        $finish;
    end

endmodule
